// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - sequential double-dabble binary to BCD converter with 7-segment decode
// One bit per SHIFT cycle; results and segment patterns are registered in LOAD.
module bcd_seq_conv #(
  parameter int WIDTH    = 7,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [6:0]    SEG_BLANK = 7'b1111111;
  localparam logic [6:0]    SEG_DASH  = 7'b1111110;
  localparam logic [CW-1:0] CNT_INIT  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg_dec = 7'b0000001;
      4'd1:    seg_dec = 7'b1001111;
      4'd2:    seg_dec = 7'b0010010;
      4'd3:    seg_dec = 7'b0000110;
      4'd4:    seg_dec = 7'b1001100;
      4'd5:    seg_dec = 7'b0100100;
      4'd6:    seg_dec = 7'b0100000;
      4'd7:    seg_dec = 7'b0001111;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0001100;
      default: seg_dec = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_lat_q, ovf_lat_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [SW-1:0]     seg_q, seg_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [SW-1:0]       seg_new;
  logic                nz_seen;
  logic                in_ovf;

  assign in_ovf = {{(32-WIDTH){1'b0}}, bin} >= LIMIT;

  always_comb begin
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
    end
    shifted = {adj, sh_q};
    shifted = shifted << 1;
  end

  // Walk from the top digit so leading zeros blank until the first nonzero digit.
  always_comb begin
    seg_new = '1;
    nz_seen = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (scr_q[4*k +: 4] != 4'd0) nz_seen = 1'b1;
      if (ovf_lat_q)
        seg_new[7*k +: 7] = SEG_DASH;
      else if ((BLANK_LZ != 0) && !nz_seen && (k != 0))
        seg_new[7*k +: 7] = SEG_BLANK;
      else
        seg_new[7*k +: 7] = seg_dec(scr_q[4*k +: 4]);
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    scr_d     = scr_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    bcd_d     = bcd_q;
    seg_d     = seg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          sh_d      = bin;
          scr_d     = '0;
          cnt_d     = CNT_INIT;
          ovf_lat_d = in_ovf;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted[BW+WIDTH-1:WIDTH];
        sh_d  = shifted[WIDTH-1:0];
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) state_d = LOAD;
      end
      LOAD: begin
        bcd_d   = scr_q;
        seg_d   = seg_new;
        ovf_d   = ovf_lat_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // busy stays up through the done cycle so both drop on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      ovf_lat_q <= 1'b0;
      bcd_q     <= '0;
      seg_q     <= '1;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      scr_q     <= scr_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      bcd_q     <= bcd_d;
      seg_q     <= seg_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb/tb_bcd_seq_conv.sv - scoreboard bench for bcd_seq_conv in three parameterisations
// Stimulus pushes expected results; per-instance monitors pop and compare on done.
module tb_bcd_seq_conv;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0001100;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b1111110;

  typedef struct packed {
    logic [11:0] bcd;
    logic [20:0] seg;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  bin;

  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [20:0] seg_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_b;
  logic [20:0] seg_b;
  logic        busy_c, done_c, ovf_c;
  logic [7:0]  bcd_c;
  logic [13:0] seg_c;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic [6:0] vec [7] = '{7'd0, 7'd19, 7'd127, 7'd5, 7'd100, 7'd42, 7'd99};

  exp_t tab_a [7] = '{
    '{12'h000, {BL, BL, S0}, 1'b0},
    '{12'h019, {BL, S1, S9}, 1'b0},
    '{12'h127, {S1, S2, S7}, 1'b0},
    '{12'h005, {BL, BL, S5}, 1'b0},
    '{12'h100, {S1, S0, S0}, 1'b0},
    '{12'h042, {BL, S4, S2}, 1'b0},
    '{12'h099, {BL, S9, S9}, 1'b0}
  };

  exp_t tab_b [7] = '{
    '{12'h000, {S0, S0, S0}, 1'b0},
    '{12'h019, {S0, S1, S9}, 1'b0},
    '{12'h127, {S1, S2, S7}, 1'b0},
    '{12'h005, {S0, S0, S5}, 1'b0},
    '{12'h100, {S1, S0, S0}, 1'b0},
    '{12'h042, {S0, S4, S2}, 1'b0},
    '{12'h099, {S0, S9, S9}, 1'b0}
  };

  exp_t tab_c [7] = '{
    '{12'h000, {7'd0, BL, S0}, 1'b0},
    '{12'h019, {7'd0, S1, S9}, 1'b0},
    '{12'h027, {7'd0, DA, DA}, 1'b1},
    '{12'h005, {7'd0, BL, S5}, 1'b0},
    '{12'h000, {7'd0, DA, DA}, 1'b1},
    '{12'h042, {7'd0, S4, S2}, 1'b0},
    '{12'h099, {7'd0, S9, S9}, 1'b0}
  };

  bcd_seq_conv dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a), .seg(seg_a)
  );

  bcd_seq_conv #(.BLANK_LZ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b), .seg(seg_b)
  );

  bcd_seq_conv #(.DIGITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_c), .done(done_c), .ovf(ovf_c), .bcd(bcd_c), .seg(seg_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      if (qa.size() == 0) check("a_unexpected_done", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        check("a_bcd", 32'(bcd_a), 32'(e.bcd));
        check("a_seg", 32'(seg_a), 32'(e.seg));
        check("a_ovf", 32'(ovf_a), 32'(e.ovf));
        check("a_busy_with_done", 32'(busy_a), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_b) begin
      if (qb.size() == 0) check("b_unexpected_done", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        check("b_bcd", 32'(bcd_b), 32'(e.bcd));
        check("b_seg", 32'(seg_b), 32'(e.seg));
        check("b_ovf", 32'(ovf_b), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_c) begin
      if (qc.size() == 0) check("c_unexpected_done", 32'd1, 32'd0);
      else begin
        e = qc.pop_front();
        check("c_bcd", 32'(bcd_c), 32'(e.bcd[7:0]));
        check("c_seg", 32'(seg_c), 32'(e.seg[13:0]));
        check("c_ovf", 32'(ovf_c), 32'(e.ovf));
      end
    end
  end

  task automatic push_exp(input int idx);
    qa.push_back(tab_a[idx]);
    qb.push_back(tab_b[idx]);
    qc.push_back(tab_c[idx]);
  endtask

  task automatic wait_done(input string name, input int first);
    int cyc;
    cyc = first;
    while (!done_a && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(cyc), 32'd9);
  endtask

  task automatic convert(input int idx, input bit b2b);
    if (!b2b) @(negedge clk);
    push_exp(idx);
    bin   = vec[idx];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_during", 32'(busy_a), 32'd1);
    wait_done("latency", 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_a), 32'd0);
    check({tag, "_bcd"}, 32'(bcd_a), 32'd0);
    check({tag, "_seg"}, 32'(seg_a), 32'h1FFFFF);
    check({tag, "_seg_c"}, 32'(seg_c), 32'h3FFF);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) convert(i, 1'b0);
    convert(5, 1'b0);
    convert(6, 1'b1);

    // a second start mid-conversion must be dropped; the late bin change must not leak in
    @(negedge clk);
    push_exp(5);
    bin   = 7'd42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bin   = 7'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_latency", 4);
    repeat (15) @(negedge clk);
    check("hold_bcd", 32'(bcd_a), 32'h042);
    check("hold_seg", 32'({BL, S4, S2}), 32'(seg_a));
    check("idle_busy", 32'(busy_a), 32'd0);

    @(negedge clk);
    bin   = 7'd127;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    rst_n = 1'b0;
    start = 1'b1;
    bin   = 7'd19;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("start_in_reset_busy", 32'(busy_a), 32'd0);
    repeat (12) @(negedge clk);

    convert(1, 1'b0);
    convert(2, 1'b0);
    repeat (3) @(negedge clk);

    check("qa_empty", 32'(qa.size()), 32'd0);
    check("qb_empty", 32'(qb.size()), 32'd0);
    check("qc_empty", 32'(qc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
